// File: rtl/axi_wdata_router_if.sv
// W-channel bundle for the write-data router: one slave-side W stream in,
// N_INIT_PORT one-hot master-side valid/ready pairs out.
// The "slave" modport is the router's view; "master" is the driver/bench view.
//   wvalid, wlast : slave-side W valid / last (into router)
//   wready        : slave-side W ready (from router)
//   wvalid_m      : per-master W valid (from router)
//   wready_m      : per-master W ready (into router)
interface axi_wdata_router_if #(
    parameter int N_INIT_PORT = 4
);
    logic                   wvalid;
    logic                   wlast;
    logic                   wready;
    logic [N_INIT_PORT-1:0] wvalid_m;
    logic [N_INIT_PORT-1:0] wready_m;

    modport slave (
        input  wvalid,
        input  wlast,
        input  wready_m,
        output wready,
        output wvalid_m
    );

    modport master (
        output wvalid,
        output wlast,
        output wready_m,
        input  wready,
        input  wvalid_m
    );
endinterface

// File: rtl/axi_wdata_router.sv
// Routes W beats to the one-hot master chosen by queued {DEST,len,error} entries.
// Latency: entry pushed at edge t is loaded at edge t+1; beats pass through combinationally.
// Backpressure: wready follows the selected master's wready; error bursts are absorbed.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   push_DEST_i, DEST_i, len_i,
//   error_i, grant_FIFO_DEST_o     : routing-entry push side (grant = FIFO not full)
//   w_if                           : W channel bundle (slave modport)
//   wdata_error_completed_o        : pulse after the final absorbed beat of an error burst
//   wlast_mismatch_o               : pulse after a beat whose wlast disagreed with the count
//   outstanding_o                  : queued entries plus the active burst
module axi_wdata_router #(
    parameter int N_INIT_PORT = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_DEST_i,
    input  logic [N_INIT_PORT-1:0]            DEST_i,
    input  logic [LEN_WIDTH-1:0]              len_i,
    input  logic                              error_i,
    output logic                              grant_FIFO_DEST_o,
    axi_wdata_router_if.slave                 w_if,
    output logic                              wdata_error_completed_o,
    output logic                              wlast_mismatch_o,
    output logic [$clog2(FIFO_DEPTH+2)-1:0]   outstanding_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 2);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [N_INIT_PORT-1:0] dest;
        logic [LEN_WIDTH-1:0]   len;
        logic                   err;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, ABSORB} state_t;

    entry_t                 mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [N_INIT_PORT-1:0] cur_dest_q;
    logic                   err_done_q;
    logic                   mismatch_q;

    logic   full, empty, push_ok, pop, beat, final_beat, dest_onehot;
    entry_t head;

    assign full              = (count_q == CW'(FIFO_DEPTH));
    assign empty             = (count_q == '0);
    assign grant_FIFO_DEST_o = ~full;
    assign push_ok           = push_DEST_i & ~full;
    assign head              = mem_q[rd_ptr_q];

    // A corrupted (non-one-hot) destination never drives any master valid.
    assign dest_onehot = (cur_dest_q != '0) &&
                         ((cur_dest_q & (cur_dest_q - N_INIT_PORT'(1))) == '0);

    always_comb begin
        w_if.wready   = 1'b0;
        w_if.wvalid_m = '0;
        case (state_q)
            ACTIVE: begin
                if (dest_onehot) begin
                    w_if.wready   = |(w_if.wready_m & cur_dest_q);
                    w_if.wvalid_m = w_if.wvalid ? cur_dest_q : '0;
                end
            end
            ABSORB:  w_if.wready = 1'b1;
            default: ;
        endcase
    end

    // cnt holds beats remaining minus one, so len=all-ones gives 2^LEN_WIDTH beats.
    assign beat       = w_if.wvalid & w_if.wready;
    assign final_beat = beat & (cnt_q == '0);
    // Pop when idle, or on the final beat so the next burst starts without a bubble.
    assign pop        = ~empty & ((state_q == IDLE) | final_beat);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    // Storage needs no reset: the pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= {DEST_i, len_i, error_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_dest_q <= '0;
            err_done_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            err_done_q <= 1'b0;
            mismatch_q <= beat & (w_if.wlast != (cnt_q == '0));
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cnt_q      <= head.len;
                        cur_dest_q <= head.dest;
                        state_q    <= head.err ? ABSORB : ACTIVE;
                    end
                end
                default: begin
                    if (final_beat) begin
                        err_done_q <= (state_q == ABSORB);
                        if (pop) begin
                            cnt_q      <= head.len;
                            cur_dest_q <= head.dest;
                            state_q    <= head.err ? ABSORB : ACTIVE;
                        end else begin
                            cur_dest_q <= '0;
                            state_q    <= IDLE;
                        end
                    end else if (beat) begin
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign wdata_error_completed_o = err_done_q;
    assign wlast_mismatch_o        = mismatch_q;
    assign outstanding_o           = count_q + CW'(state_q != IDLE);
endmodule

// File: tb/tb_axi_wdata_router.sv
// Bench for axi_wdata_router: queue-based burst model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axi_wdata_router;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [N-1:0]  dest;
    logic [LW-1:0] len;
    logic          err;
    logic          grant;
    logic          errp;
    logic          mism;
    logic [3:0]    outst;

    axi_wdata_router_if #(.N_INIT_PORT(N)) wif ();

    axi_wdata_router #(.N_INIT_PORT(N), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .push_DEST_i             (push),
        .DEST_i                  (dest),
        .len_i                   (len),
        .error_i                 (err),
        .grant_FIFO_DEST_o       (grant),
        .w_if                    (wif),
        .wdata_error_completed_o (errp),
        .wlast_mismatch_o        (mism),
        .outstanding_o           (outst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [N-1:0] dest;
        int           beats;
        bit           err;
    } ent_t;

    ent_t         mq[$];
    bit           m_act  = 1'b0;
    logic [N-1:0] m_dest = '0;
    int           m_rem  = 0;
    bit           m_err  = 1'b0;
    bit           m_errp = 1'b0;
    bit           m_mism = 1'b0;

    function automatic logic exp_wready();
        return m_act && (m_err || (|(wif.wready_m & m_dest)));
    endfunction

    function automatic logic [N-1:0] exp_wvalid_m();
        return (m_act && !m_err && wif.wvalid) ? m_dest : '0;
    endfunction

    task automatic m_load();
        ent_t e;
        e      = mq.pop_front();
        m_act  = 1'b1;
        m_dest = e.dest;
        m_rem  = e.beats;
        m_err  = e.err;
    endtask

    always @(posedge clk) begin
        bit   can_push, bt, n_err, n_mism;
        ent_t ne;
        if (rst) begin
            mq.delete();
            m_act  = 1'b0;
            m_dest = '0;
            m_rem  = 0;
            m_err  = 1'b0;
            m_errp = 1'b0;
            m_mism = 1'b0;
        end else begin
            assert (!(push && grant) || $onehot(dest)) else $error("pushed destination is not one-hot");
            can_push = (mq.size() < DEPTH);
            bt       = wif.wvalid && exp_wready();
            n_err    = 1'b0;
            n_mism   = 1'b0;
            if (!m_act) begin
                if (mq.size() > 0) m_load();
            end else if (bt) begin
                n_mism = (wif.wlast != (m_rem == 1));
                if (m_rem == 1) begin
                    n_err = m_err;
                    if (mq.size() > 0) m_load();
                    else m_act = 1'b0;
                end else begin
                    m_rem--;
                end
            end
            if (push && can_push) begin
                ne.dest  = dest;
                ne.beats = int'(len) + 1;
                ne.err   = err;
                mq.push_back(ne);
            end
            m_errp = n_err;
            m_mism = n_mism;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("wvalid_m", wif.wvalid_m, exp_wvalid_m());
            chk("wready", wif.wready, exp_wready());
            chk("grant", grant, (mq.size() < DEPTH));
            chk("outstanding", outst, mq.size() + int'(m_act));
            chk("err_pulse", errp, m_errp);
            chk("mism_pulse", mism, m_mism);
        end
    end

    // ---------------- activity monitor for literal checks ----------------
    int cyc = 0;
    int fwd_cnt[N];
    int lb_cyc[N];
    int s_beat_cyc = -1;
    int err_cnt = 0;
    int err_cyc = -1;
    int mism_cnt = 0;
    int first_fwd_cyc = -1;

    always @(posedge clk) cyc++;

    initial begin
        for (int p = 0; p < N; p++) begin
            fwd_cnt[p] = 0;
            lb_cyc[p]  = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (wif.wvalid_m != '0 && first_fwd_cyc < 0) first_fwd_cyc = cyc;
            for (int p = 0; p < N; p++) begin
                if (wif.wvalid_m[p] && wif.wready_m[p]) begin
                    fwd_cnt[p]++;
                    lb_cyc[p] = cyc;
                end
            end
            if (wif.wvalid && wif.wready) s_beat_cyc = cyc;
            if (errp) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (mism) mism_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [N-1:0] d, input logic [LW-1:0] l, input logic e);
        push = 1'b1;
        dest = d;
        len  = l;
        err  = e;
        tick();
        push = 1'b0;
    endtask

    // Drive n accepted beats; wlast on every beat when la<0, else on beats la and lb.
    task automatic send(input int n, input int la, input int lb);
        int   k = 1;
        int   guard = 0;
        logic acc;
        while (k <= n && guard < 1000) begin
            wif.wvalid = 1'b1;
            wif.wlast  = (la < 0) || (k == la) || (k == lb);
            @(negedge clk);
            acc = wif.wready;
            tick();
            if (acc) k++;
            guard++;
        end
        wif.wvalid = 1'b0;
        wif.wlast  = 1'b0;
        chk("send_done", k, n + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_edge;
        int s0, s1, s2, s3, e0, m0;

        rst          = 1'b1;
        push         = 1'b0;
        dest         = '0;
        len          = '0;
        err          = 1'b0;
        wif.wvalid   = 1'b0;
        wif.wlast    = 1'b0;
        wif.wready_m = '0;
        repeat (2) tick();
        // Push coincides with the last reset edge: must not be stored.
        push = 1'b1;
        dest = 4'b0001;
        tick();
        rst    = 1'b0;
        push   = 1'b0;
        chk_en = 1'b1;
        chk("rst_outst", outst, 0);
        chk("rst_wready", wif.wready, 0);
        chk("rst_wvalid", wif.wvalid_m, 0);
        chk("rst_grant", grant, 1);
        chk("rst_pulses", {errp, mism}, 0);
        repeat (2) tick();
        chk("rst_push_dropped", outst, 0);

        // Single burst to port1, 4 beats.
        wif.wready_m = 4'b1111;
        s1 = fwd_cnt[1];
        push_one(4'b0010, 8'd3, 1'b0);
        p_edge = cyc;
        chk("a_outst_queued", outst, 1);
        send(4, 4, 0);
        // Entry written at edge p_edge, loaded at the next edge, forwarded right after.
        chk("a_first_fwd", first_fwd_cyc, p_edge + 1);
        chk("a_beats_p1", fwd_cnt[1] - s1, 4);
        chk("a_outst_done", outst, 0);
        chk("a_no_pulses", err_cnt + mism_cnt, 0);

        // Back-to-back bursts, no bubble between port0 and port3.
        s0 = fwd_cnt[0];
        s3 = fwd_cnt[3];
        push_one(4'b0001, 8'd0, 1'b0);
        push_one(4'b1000, 8'd1, 1'b0);
        send(3, 1, 3);
        chk("b_beats_p0", fwd_cnt[0] - s0, 1);
        chk("b_beats_p3", fwd_cnt[3] - s3, 2);
        chk("b_no_bubble", lb_cyc[3] - lb_cyc[0], 2);

        // Error burst absorbed with all masters stalled.
        wif.wready_m = 4'b0000;
        s2 = fwd_cnt[2];
        e0 = err_cnt;
        push_one(4'b0100, 8'd2, 1'b1);
        send(3, 3, 0);
        tick();
        chk("c_err_pulses", err_cnt - e0, 1);
        chk("c_err_timing", err_cyc, s_beat_cyc + 1);
        chk("c_beats_p2", fwd_cnt[2] - s2, 0);
        chk("c_outst", outst, 0);

        // Fill, overflow, free a slot, then push concurrent with a final beat.
        wif.wready_m = 4'b1111;
        s0 = fwd_cnt[0];
        s3 = fwd_cnt[3];
        for (int i = 0; i < 9; i++) push_one(4'b0001, 8'd0, 1'b0);
        chk("d_full_grant", grant, 0);
        chk("d_full_outst", outst, 9);
        push_one(4'b1000, 8'd0, 1'b0);
        chk("d_drop_outst", outst, 9);
        send(1, -1, 0);
        chk("d_free_grant", grant, 1);
        chk("d_free_outst", outst, 8);
        push       = 1'b1;
        dest       = 4'b0001;
        len        = 8'd0;
        err        = 1'b0;
        wif.wvalid = 1'b1;
        wif.wlast  = 1'b1;
        tick();
        push       = 1'b0;
        wif.wvalid = 1'b0;
        wif.wlast  = 1'b0;
        chk("d_pushpop_outst", outst, 8);
        send(8, -1, 0);
        chk("d_drain_outst", outst, 0);
        chk("d_beats_p0", fwd_cnt[0] - s0, 10);
        chk("d_beats_p3", fwd_cnt[3] - s3, 0);

        // wlast on beat 2 of 4: pulses after beat 2 and beat 4.
        m0 = mism_cnt;
        s0 = fwd_cnt[0];
        push_one(4'b0001, 8'd3, 1'b0);
        send(4, 2, 0);
        tick();
        chk("e_mism_pulses", mism_cnt - m0, 2);
        chk("e_beats_p0", fwd_cnt[0] - s0, 4);
        chk("e_outst", outst, 0);

        // Reset during beat 2 of a 4-beat burst with two entries queued.
        s2 = fwd_cnt[2];
        s3 = fwd_cnt[3];
        push_one(4'b0010, 8'd3, 1'b0);
        push_one(4'b0100, 8'd1, 1'b0);
        push_one(4'b1000, 8'd0, 1'b0);
        send(1, 0, 0);
        wif.wvalid = 1'b1;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        wif.wvalid = 1'b0;
        chk("f_rst_outst", outst, 0);
        chk("f_rst_wready", wif.wready, 0);
        chk("f_rst_grant", grant, 1);
        repeat (3) tick();
        chk("f_lost_p2", fwd_cnt[2] - s2, 0);
        chk("f_lost_p3", fwd_cnt[3] - s3, 0);
        push_one(4'b0100, 8'd0, 1'b0);
        send(1, 1, 0);
        chk("f_new_p2", fwd_cnt[2] - s2, 1);
        chk("f_new_outst", outst, 0);

        // Maximum length burst: 256 beats, counter must not wrap early.
        s3 = fwd_cnt[3];
        m0 = mism_cnt;
        push_one(4'b1000, 8'hff, 1'b0);
        send(255, 0, 0);
        chk("g_still_active", outst, 1);
        send(1, 1, 0);
        tick();
        chk("g_beats_p3", fwd_cnt[3] - s3, 256);
        chk("g_mism", mism_cnt - m0, 0);
        chk("g_outst", outst, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_wdata_router.md
AXI_WDATA_ROUTER -- requirements
Module: axi_wdata_router

Interface
REQ-001 Parameter N_INIT_PORT, default 4, number of master ports (one-hot destination width).
REQ-002 Parameter FIFO_DEPTH, default 8, routing-entry FIFO depth, >=2.
REQ-003 Parameter LEN_WIDTH, default 8, burst-length field width (beats-1, AXI4 AWLEN).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 push_DEST_i  in  1  push routing entry.
REQ-007 DEST_i  in  N_INIT_PORT  one-hot destination of entry.
REQ-008 len_i  in  LEN_WIDTH  entry burst length minus one.
REQ-009 error_i  in  1  entry is a decode-error burst (absorb, do not forward).
REQ-010 grant_FIFO_DEST_o  out  1  entry FIFO not full.
REQ-011 wvalid_i / wlast_i  in  1 / 1  slave-side W valid and last.
REQ-012 wready_o  out  1  slave-side W ready.
REQ-013 wvalid_o  out  N_INIT_PORT  per-master W valid.
REQ-014 wready_i  in  N_INIT_PORT  per-master W ready.
REQ-015 wdata_error_completed_o  out  1  one-cycle pulse: error burst fully absorbed.
REQ-016 wlast_mismatch_o  out  1  one-cycle pulse: wlast_i disagreed with beat count.
REQ-017 outstanding_o  out  $clog2(FIFO_DEPTH+2)  queued entries plus active burst.

Function
REQ-018 Entry FIFO: registered, no fall-through, stores {DEST, len, error}; in-order.
REQ-019 Push accepted only when push_DEST_i & grant_FIFO_DEST_o; push while full ignored, contents unchanged.
REQ-020 grant_FIFO_DEST_o = ~full, from registered count only.
REQ-021 FSM states IDLE, ACTIVE, ABSORB; current-burst registers cur_dest, beat counter cnt (LEN_WIDTH).
REQ-022 IDLE, FIFO non-empty: pop head, cnt<=len, cur_dest<=DEST; go ABSORB if error else ACTIVE.
REQ-023 Push at edge t -> earliest forwarded wvalid_o in cycle t+2 (entry visible t+1, loaded end of t+1).
REQ-024 Beat = wvalid_i & wready_o; on non-final beat cnt decrements by 1.
REQ-025 Final beat = beat with cnt==0; ends burst regardless of wlast_i.
REQ-026 On final beat, FIFO non-empty: load next head same edge (no bubble); else go IDLE.
REQ-027 ACTIVE: wvalid_o = wvalid_i ? cur_dest : 0; wready_o = |(wready_i & cur_dest).
REQ-028 ABSORB: wvalid_o = 0; wready_o = 1.
REQ-029 IDLE: wvalid_o = 0; wready_o = 0.
REQ-030 wdata_error_completed_o pulses high the cycle after final beat in ABSORB, exactly once per error entry.
REQ-031 wlast_mismatch_o pulses the cycle after a beat where wlast_i != (cnt==0); routing unaffected.
REQ-032 Simultaneous push and pop: count unchanged, both take effect; full never blocks a pop.
REQ-033 outstanding_o = FIFO count + (state != IDLE); max FIFO_DEPTH+1.
REQ-034 len_i all-ones: burst of 2^LEN_WIDTH beats, counter must not wrap early.
REQ-035 wvalid_o never asserted for non-one-hot DEST; DEST_i assumed one-hot by upstream (assertion in bench).

Reset
REQ-036 rst high at edge: FIFO emptied, state IDLE, cnt 0, cur_dest 0; in-flight burst discarded.
REQ-037 During/after reset cycle: wready_o 0, wvalid_o 0, grant_FIFO_DEST_o 1, pulses 0, outstanding_o 0.
REQ-038 Push asserted in same cycle as rst is dropped (not stored).

Verification
REQ-039 Push {DEST=0010,len=3,err=0}; W stream 4 beats, wlast on 4th, wready_i=1111 -> wvalid_o=0010 from cycle t+2, 4 beats forwarded, outstanding 1->0, no pulses.
REQ-040 Push {0001,len=0,0}, {1000,len=1,0} back-to-back; continuous wvalid_i -> beats on port0 then port3 with no idle cycle between bursts.
REQ-041 Push {0100,len=2,err=1}; 3 beats with wready_i=0 -> wready_o=1 each beat, wvalid_o=0, wdata_error_completed_o single pulse after 3rd beat.
REQ-042 Fill FIFO_DEPTH entries with W stalled -> grant 0, extra push dropped; first beat accepted frees slot; concurrent push+final-beat keeps count constant.
REQ-043 len=3, wlast_i on beat 2 -> wlast_mismatch_o pulses after beats 2 and 4; burst still ends after beat 4.
REQ-044 Assert rst mid-burst (beat 2 of 4) -> next cycle outstanding_o 0, wready_o 0, queued entries lost; new push routes normally.
